// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: connects the EX-stage pipeline to the iterative multiply/divide unit.
//   master modport (pipeline side): drives start_i, flush_i, funct3_i, rs1_i, rs2_i and rd_i,
//                                   and receives stall_o, busy_o, done_o, result_o, rd_o and reg_write_o.
//   slave modport (unit side):      the same signals with the directions reversed.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;
  logic            reg_write_o;

  modport master (
    output start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
    input  stall_o, busy_o, done_o, result_o, rd_o, reg_write_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, rs1_i, rs2_i, rd_i,
    output stall_o, busy_o, done_o, result_o, rd_o, reg_write_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit in the EX stage.
// It computes one radix-2 step per cycle: shift-add for multiply and restoring
// subtraction for divide. It works on operand magnitudes and corrects the sign of
// the final result.
//   clk, reset : clock and asynchronous active-low reset.
//   bus        : ex_muldiv_if.slave, which carries the following:
//                start/flush/funct3/rs1/rs2/rd in,
//                stall/busy/done/result/rd_o/reg_write out.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  ex_muldiv_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     opnd_reg;     // multiplicand or divisor magnitude
  logic [2:0]          f3_reg;
  logic                neg_q_reg;    // negate product/quotient
  logic                neg_r_reg;    // negate remainder (dividend sign)
  logic [4:0]          rd_pend_reg;
  logic [XLEN-1:0]     result_reg;
  logic [4:0]          rd_reg;

  // ---------------- start-time decode ----------------
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic            div_zero, div_ovf, special, accept, last_step;

  always_comb begin
    // For divides, the even funct3 codes are signed. For multiplies, MULH treats both
    // operands as signed and MULHSU treats only rs1 as signed. MUL's low half is sign-agnostic.
    a_signed = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1] ^ bus.funct3_i[0]);
    b_signed = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] == 2'b01);
    sign_a   = a_signed & bus.rs1_i[XLEN-1];
    sign_b   = b_signed & bus.rs2_i[XLEN-1];
    mag_a    = sign_a ? -bus.rs1_i : bus.rs1_i;
    mag_b    = sign_b ? -bus.rs2_i : bus.rs2_i;
    div_zero = bus.funct3_i[2] && (bus.rs2_i == '0);
    div_ovf  = bus.funct3_i[2] && !bus.funct3_i[0] &&
               (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
    else
      special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept    = (state_reg == IDLE) && bus.start_i && !bus.flush_i;
    last_step = (cnt_reg == CNT_W'(XLEN-1));
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_reg};
    // When div_ge is true, the difference is below the divisor and fits in XLEN bits.
    div_sub   = div_shift[XLEN-1:0] - opnd_reg;
    if (f3_reg[2])
      acc_next = div_ge ? {div_sub, acc_reg[XLEN-2:0], 1'b1}
                        : {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc_reg[XLEN-1:1]};

    prod_fix = neg_q_reg ? -acc_next : acc_next;
    quo_fix  = neg_q_reg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix  = neg_r_reg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (f3_reg[2])
      calc_res = f3_reg[1] ? rem_fix : quo_fix;
    else
      calc_res = (f3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (bus.flush_i)    state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      f3_reg      <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rd_pend_reg <= '0;
      result_reg  <= '0;
      rd_reg      <= '0;
    end else if (accept) begin
      cnt_reg     <= '0;
      f3_reg      <= bus.funct3_i;
      rd_pend_reg <= bus.rd_i;
      neg_q_reg   <= sign_a ^ sign_b;
      neg_r_reg   <= sign_a;
      if (bus.funct3_i[2]) begin
        acc_reg  <= {{XLEN{1'b0}}, mag_a};
        opnd_reg <= mag_b;
      end else begin
        acc_reg  <= {{XLEN{1'b0}}, mag_b};
        opnd_reg <= mag_a;
      end
      if (special) begin
        result_reg <= special_res;
        rd_reg     <= bus.rd_i;
      end
    end else if (state_reg == CALC && !bus.flush_i) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (last_step) begin
        result_reg <= calc_res;
        rd_reg     <= rd_pend_reg;
      end
    end
  end

  assign bus.stall_o     = accept || (state_reg == CALC);
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.done_o      = (state_reg == DONE);
  assign bus.reg_write_o = (state_reg == DONE);
  assign bus.result_o    = result_reg;
  assign bus.rd_o        = rd_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus();

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      pass_cnt++;
  endtask

  // Called on a falling edge. The task issues one op and waits for done_o, which is
  // bounded at 40 edges. It checks the latency, the stall length, the result, the tag,
  // and whether the result is held afterwards. With noise set, extra start requests are
  // driven while the unit is busy.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat, input bit noise);
    int edges;
    int stalls;
    bit seen;
    edges = 0; stalls = 0; seen = 1'b0;
    bus.funct3_i = f3; bus.rs1_i = a; bus.rs2_i = b; bus.rd_i = rd; bus.start_i = 1'b1;
    while (!seen && edges < 40) begin
      #1;
      if (bus.stall_o) stalls++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
      if (noise && !seen && edges >= 3) begin
        bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.rs1_i = 32'd9;
        bus.rs2_i = 32'd3; bus.rd_i = 5'd7;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(lat));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(lat));
    check({tag, " result"}, bus.result_o, exp);
    check({tag, " rd"}, {27'd0, bus.rd_o}, {27'd0, rd});
    check({tag, " reg_write"}, 32'(bus.reg_write_o), 32'd1);
    check({tag, " stall_in_done"}, 32'(bus.stall_o), 32'd0);
    $display("op %s f3=%0d rs1=0x%08h rs2=0x%08h -> result=0x%08h rd=%0d latency=%0d",
             tag, f3, a, b, bus.result_o, bus.rd_o, edges);
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(bus.done_o), 32'd0);
    check({tag, " idle_after"}, 32'(bus.busy_o), 32'd0);
    check({tag, " result_held"}, bus.result_o, exp);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = 3'd0;
    bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;

    #12;
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst stall", 32'(bus.stall_o), 32'd0);
    check("rst result", bus.result_o, 32'd0);
    check("rst rd", {27'd0, bus.rd_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("MUL",    3'b000, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 1'b0);
    do_op("MULH",   3'b001, 32'h80000000,   32'h80000000, 5'd6,  32'h40000000, 33, 1'b0);
    do_op("MULHU",  3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, 1'b0);
    do_op("MULHSU", 3'b010, 32'hFFFFFFFF,   32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b0);
    do_op("DIV",    3'b100, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 33, 1'b0);
    do_op("REM",    3'b110, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 33, 1'b0);
    do_op("DIVU",   3'b101, 32'd100,        32'd7,        5'd11, 32'd14,       33, 1'b0);
    do_op("REMU",   3'b111, 32'd100,        32'd7,        5'd12, 32'd2,        33, 1'b0);
    do_op("DIVU0",  3'b101, 32'h1234,       32'd0,        5'd13, 32'hFFFFFFFF, 1,  1'b0);
    do_op("REM0",   3'b110, 32'h1234,       32'd0,        5'd14, 32'h1234,     1,  1'b0);
    do_op("DIVOVF", 3'b100, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  1'b0);
    do_op("REMOVF", 3'b110, 32'h80000000,   32'hFFFFFFFF, 5'd16, 32'd0,        1,  1'b0);

    // A start request that arrives together with a flush is not accepted.
    bus.funct3_i = 3'b000; bus.rs1_i = 32'd3; bus.rs2_i = 32'd4; bus.rd_i = 5'd2;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    check("flush_idle stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("flush_idle busy", 32'(bus.busy_o), 32'd0);

    // Flush during the 10th cycle of CALC.
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("flush_calc no_done", 32'(bus.done_o), 32'd0);
    end
    check("flush_calc busy_before", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_calc busy", 32'(bus.busy_o), 32'd0);
    check("flush_calc stall", 32'(bus.stall_o), 32'd0);
    check("flush_calc done", 32'(bus.done_o), 32'd0);
    do_op("DIVU_after_flush", 3'b101, 32'd9, 32'd3, 5'd3, 32'd3, 33, 1'b0);

    // Assert reset asynchronously during the 20th cycle of CALC.
    bus.funct3_i = 3'b000; bus.rs1_i = 32'd7; bus.rs2_i = 32'hFFFFFFFD; bus.rd_i = 5'd5;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy_o), 32'd0);
    check("midrst stall", 32'(bus.stall_o), 32'd0);
    check("midrst done", 32'(bus.done_o), 32'd0);
    check("midrst reg_write", 32'(bus.reg_write_o), 32'd0);
    check("midrst result", bus.result_o, 32'd0);
    check("midrst rd", {27'd0, bus.rd_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op("MUL_ignored_starts", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched operands, funct3 and destination register of M-extension instructions.
- Computes over multiple cycles while stalling the pipeline front end.
- Returns a 32-bit result and the rd tag for the EX/MEM register to capture.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  ID/EX holds a valid M-extension op; sampled only in IDLE
- flush_i  input  1  abort current/pending op (branch/jalr redirect)
- funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  input  32  operand A (ID_EX read data 1)
- rs2_i  input  32  operand B (ID_EX read data 2)
- rd_i  input  5  destination register tag
- stall_o  output  1  hold PC, IF/ID and ID/EX
- busy_o  output  1  unit not in IDLE
- done_o  output  1  one-cycle result-valid pulse
- result_o  output  32  result, valid while done_o=1, held until next done
- rd_o  output  5  tag of result_o
- reg_write_o  output  1  equals done_o; write-enable toward EX/MEM

Behaviour:
- Reset (reset=0, async): state=IDLE; counter, accumulators and all outputs 0.
- A reset mid-operation discards the op; no done_o is produced for it.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch funct3, rd, and operand magnitudes and signs per op signedness.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Special divide cases go to DONE on the next edge. All other ops go to CALC with counter=0.
- Special divide cases (decided at start):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply (64-bit product), restoring subtract for divide.
  - Counter increments each cycle. After the step with counter=31, go to DONE.
  - Result is sign-corrected: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
- DONE: done_o=1 and reg_write_o=1 for exactly one cycle; result_o and rd_o valid; next state IDLE.
- Latency:
  - Normal ops: done_o high in the cycle after the 33rd rising edge counted from (and including) the edge that samples start_i.
  - Special divide cases: done_o high after 1 edge.
- stall_o is combinational: (IDLE and start_i and not flush_i) or CALC. It is low in DONE so the pipeline advances and EX/MEM captures result_o.
- busy_o = (state != IDLE).
- start_i outside IDLE is ignored; no queueing.
- flush_i:
  - In IDLE with start_i: start is not accepted.
  - In CALC: return to IDLE next edge, no done_o.
  - In DONE: ignored; the result is still delivered.
- result_o and rd_o keep their last value after DONE; they are updated only on entry to DONE.
- Unit is not pipelined; back-to-back starts are accepted from the IDLE cycle after DONE.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), rd=5 -> stall_o high 33 cycles; done_o pulse with result_o=0xFFFFFFEB, rd_o=5, reg_write_o=1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU x/0 with x=0x1234 -> 0xFFFFFFFF after 1 edge; REM x/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Start MUL, assert flush_i in CALC cycle 10 -> IDLE next edge, no done_o, stall_o low. Immediate new DIVU 9/3 completes with 3.
- Assert reset low in CALC cycle 20 -> all outputs 0 asynchronously. After release, start_i while busy is ignored and does not corrupt the in-flight result.
